// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder (with leaf cell fulladder)
//  Description : Bit-serial adder. Captures two WIDTH-bit operands and a
//                carry-in on start, then adds LSB-first through a single
//                full-adder cell, one bit per clock, keeping the cell's carry
//                in a flop between bits. The parallel result is presented
//                with a one-cycle done pulse WIDTH cycles after acceptance.
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous, active-high reset
//                start - request, sampled only while idle
//                a, b  - WIDTH-bit operands, captured on accepted start
//                cin   - carry-in, captured on accepted start
//                busy  - high while an addition is in progress
//                done  - one-cycle pulse when sum/cout update
//                sum   - registered result, held until the next done
//                cout  - registered carry-out, held until the next done
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  fulladder : single-bit full adder cell, purely combinational.
// ----------------------------------------------------------------------------
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// ----------------------------------------------------------------------------
//  serial_adder : top level.
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sr_next;

    fulladder u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .c     (cy),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bits enter at the MSB so that after WIDTH shifts bit 0 of the
    // result sits at sr[0]; the oldest bit drops off the bottom each cycle.
    assign sr_next = {fa_sum, sr[WIDTH-1:1]};

    // sr[0] is always shifted out before it could matter.
    logic unused_sr_lsb;
    assign unused_sr_lsb = sr[0];

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cy    <= cin;
                        cnt   <= '0;
                        sr    <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    cy  <= fa_carry;
                    cnt <= cnt + CW'(1);
                    // Final bit: publish the assembled word together with
                    // the carry produced by this very bit.
                    if (cnt == LAST) begin
                        sum   <= sr_next;
                        cout  <= fa_carry;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Drives a WIDTH=8 and
//                a WIDTH=3 instance and compares every result to a+b+cin
//                computed with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    // Reference: full-precision sum, {cout,sum}.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return r[8:0];
    endfunction

    // One WIDTH=8 transaction; lat counts edges after the accepting edge.
    task automatic run_add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                            output logic [7:0] s, output logic co, output int lat);
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s  = sum8;
        co = cout8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            b8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b sum=%h cout=%b, want 0/0/00/0",
                         i, busy8, done8, sum8, cout8);
            end
        end
    endtask

    task automatic test_basic;
        logic [8:0] exp;
        exp = model8(8'h3C, 8'h15, 1'b0);
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h15; cin8 = 1'b0; start8 = 1'b1;
        // Edge k follows; each negedge below observes edges k..k+7.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'hEE; b8 = 8'h77; cin8 = 1'b1;
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy edge k+%0d: busy=%b done=%b, want 1/0", i, busy8, done8);
            end
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || {cout8, sum8} !== exp) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b cout=%b sum=%h, want 1/0 cout=%b sum=%h",
                     done8, busy8, cout8, sum8, exp[8], exp[7:0]);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || {cout8, sum8} !== exp) begin
            errors++;
            $display("FAIL basic_pulse: done=%b sum=%h, want done=0 sum held %h", done8, sum8, exp[7:0]);
        end
    endtask

    task automatic test_carry;
        logic [7:0] ta [3] = '{8'hFF, 8'hA5, 8'h80};
        logic [7:0] tb [3] = '{8'h01, 8'h5A, 8'h80};
        logic       tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] s;
        logic       co;
        logic [8:0] exp;
        int         lat;
        for (int i = 0; i < 23; i++) begin
            logic [7:0] x, y;
            logic       c;
            if (i < 3) begin
                x = ta[i]; y = tb[i]; c = tc[i];
            end else begin
                x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            end
            exp = model8(x, y, c);
            run_add8(x, y, c, s, co, lat);
            checks++;
            if (!done8 || lat != 8 || {co, s} !== exp) begin
                errors++;
                $display("FAIL add %h+%h+%b: done=%b lat=%0d cout=%b sum=%h, want lat=8 cout=%b sum=%h",
                         x, y, c, done8, lat, co, s, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        if (done8) ndone++;
        repeat (2) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        if (done8) ndone++;
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                checks++;
                if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_start_result: cout=%b sum=%h, want 0/30", cout8, sum8);
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignore_start_count: done pulses=%0d, want 1", ndone);
        end
    endtask

    task automatic test_back_to_back;
        int         wait1 = 0, gap = 0;
        logic [8:0] exp2;
        exp2 = model8(8'h7E, 8'h99, 1'b1);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        while (!done8 && wait1 < 40) begin
            @(negedge clk);
            wait1++;
        end
        checks++;
        if (!done8 || {cout8, sum8} !== model8(8'h12, 8'h34, 1'b0)) begin
            errors++;
            $display("FAIL b2b_first: done=%b sum=%h, want done=1 sum=46", done8, sum8);
        end
        // start still high through the done cycle; next edge captures these.
        a8 = 8'h7E; b8 = 8'h99; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        gap = 1;
        while (!done8 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (!done8 || gap != 9 || {cout8, sum8} !== exp2) begin
            errors++;
            $display("FAIL b2b_second: done=%b gap=%0d cout=%b sum=%h, want gap=9 cout=%b sum=%h",
                     done8, gap, cout8, sum8, exp2[8], exp2[7:0]);
        end
    endtask

    task automatic test_reset_midop;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         ndone = 0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, want 0/0/00/0",
                     busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_abort: activity cycles after reset=%0d, want 0", ndone);
        end
        run_add8(8'h01, 8'h01, 1'b0, s, co, lat);
        checks++;
        if (!done8 || s !== 8'h02 || co !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_add: done=%b cout=%b sum=%h, want 1/0/02", done8, co, s);
        end
    endtask

    task automatic test_exhaustive3;
        logic [3:0] exp;
        int         w;
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd0; cin3 = 1'b0; start3 = 1'b1;
        for (int idx = 0; idx < 128; idx++) begin
            int x, y, c;
            x = idx[6:4]; y = idx[3:1]; c = idx[0];
            exp = 4'(x + y + c);
            w = 0;
            @(negedge clk);
            while (!done3 && w < 20) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (!done3 || {cout3, sum3} !== exp || (idx > 0 && w != 3)) begin
                errors++;
                $display("FAIL exh3 %0d+%0d+%0d: done=%b wait=%0d cout=%b sum=%0d, want cout=%b sum=%0d",
                         x, y, c, done3, w, cout3, sum3, exp[3], exp[2:0]);
            end
            if (idx < 127) begin
                a3 = 3'((idx + 1) >> 4); b3 = 3'((idx + 1) >> 1); cin3 = 1'((idx + 1) & 1);
            end else begin
                start3 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
